// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM read arbiter: requester ownership tags and
// arbitration states.
package vram_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_SIM} owner_t;

    typedef enum logic {NORMAL, FORCE_SIM} arb_state_t;

    typedef struct packed {
        owner_t owner;
        logic   oor;
    } rd_tag_t;

    localparam rd_tag_t TAG_IDLE = '{owner: OWN_NONE, oor: 1'b0};

endpackage

// File: rtl/read_tag_pipe.sv
// Latency-matched shift register carrying the owner of each VRAM read (and its
// out-of-range flag) so returning data can be steered to the right requester.
module read_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [RD_LATENCY];
    rd_tag_t stage_d [RD_LATENCY];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_o = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// Shares the single VRAM read port between display scan-out (priority) and the
// cell-update engine, with a starvation counter that forces an occasional sim grant.
module vram_read_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int RD_LATENCY     = 1,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  disp_req_i,
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    output logic                  disp_gnt_o,
    output logic                  disp_valid_o,
    output logic [DATA_WIDTH-1:0] disp_data_o,
    input  logic                  sim_req_i,
    input  logic [ADDR_WIDTH-1:0] sim_addr_i,
    output logic                  sim_gnt_o,
    output logic                  sim_valid_o,
    output logic [DATA_WIDTH-1:0] sim_data_o,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
    output logic                  range_err_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH:0] CELLS_EXT = (ADDR_WIDTH+1)'(ACTIVE_COLUMNS*ACTIVE_ROWS);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  disp_gnt, sim_gnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  oor;
    rd_tag_t               tag_in, tag_out;

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        disp_gnt = 1'b0;
        sim_gnt  = 1'b0;
        if (!reset_i) begin
            if (state_q == FORCE_SIM && sim_req_i) begin
                sim_gnt = 1'b1;
            end else if (disp_req_i) begin
                disp_gnt = 1'b1;
            end else if (sim_req_i) begin
                sim_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!sim_req_i || sim_gnt) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        state_d = (state_q == NORMAL && starve_d == CNT_MAX) ? FORCE_SIM : NORMAL;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        rd_addr = '0;
        if (sim_gnt) begin
            rd_addr = sim_addr_i;
        end else if (disp_gnt) begin
            rd_addr = disp_addr_i;
        end
        oor    = (sim_gnt || disp_gnt) && ({1'b0, rd_addr} >= CELLS_EXT);
        tag_in = '{owner: sim_gnt ? OWN_SIM : (disp_gnt ? OWN_DISP : OWN_NONE), oor: oor};
    end

    read_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    assign disp_gnt_o        = disp_gnt;
    assign sim_gnt_o         = sim_gnt;
    assign vram_rd_address_o = rd_addr;
    assign range_err_o       = oor;

    // Out-of-range reads still return a valid beat, but with the data zeroed.
    assign disp_valid_o = (tag_out.owner == OWN_DISP);
    assign sim_valid_o  = (tag_out.owner == OWN_SIM);
    assign disp_data_o  = (disp_valid_o && !tag_out.oor) ? vram_rd_data_i : '0;
    assign sim_data_o   = (sim_valid_o && !tag_out.oor) ? vram_rd_data_i : '0;

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Randomised scoreboard bench for vram_read_arbiter: grants checked against a
// starvation-rule model, returns popped and compared by an independent monitor.
module tb_vram_read_arbiter;

    localparam int COLS  = 640;
    localparam int ROWS  = 480;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = 19;
    localparam int L     = 3;
    localparam int LIM   = 4;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          disp_req_i = 1'b0;
    logic [AW-1:0] disp_addr_i = '0;
    logic          disp_gnt_o, disp_valid_o;
    logic [0:0]    disp_data_o;
    logic          sim_req_i = 1'b0;
    logic [AW-1:0] sim_addr_i = '0;
    logic          sim_gnt_o, sim_valid_o;
    logic [0:0]    sim_data_o;
    logic [AW-1:0] vram_rd_address_o;
    logic [0:0]    vram_rd_data_i;
    logic          range_err_o;

    vram_read_arbiter #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
        .DATA_WIDTH(1), .RD_LATENCY(L), .STARVE_LIMIT(LIM)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
        .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
        .sim_req_i(sim_req_i), .sim_addr_i(sim_addr_i), .sim_gnt_o(sim_gnt_o),
        .sim_valid_o(sim_valid_o), .sim_data_o(sim_data_o),
        .vram_rd_address_o(vram_rd_address_o), .vram_rd_data_i(vram_rd_data_i),
        .range_err_o(range_err_o)
    );

    always #5 clk_i = ~clk_i;

    // VRAM contents: odd-parity complement of the address.
    function automatic logic vram_word(input logic [AW-1:0] a);
        return ~^a;
    endfunction

    logic [AW-1:0] apipe [L];
    always @(posedge clk_i) begin
        apipe[0] <= vram_rd_address_o;
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign vram_rd_data_i = vram_word(apipe[L-1]);

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int   due;
        int   owner;   // 1 = display, 2 = sim
        logic data;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    int streak = 0;    // consecutive cycles sim has asked and been refused

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [AW-1:0] da,
                         input logic sr, input logic [AW-1:0] sa);
        logic es, ed;
        int   ea;
        @(posedge clk_i);
        #1;
        disp_req_i = dr; disp_addr_i = da;
        sim_req_i  = sr; sim_addr_i  = sa;
        #1;
        es = sr && (!dr || streak >= LIM);
        ed = dr && !es;
        ea = es ? int'(sa) : (ed ? int'(da) : 0);
        chk("disp_gnt", int'(disp_gnt_o), int'(ed));
        chk("sim_gnt", int'(sim_gnt_o), int'(es));
        chk("rd_addr", int'(vram_rd_address_o), ea);
        chk("range_err", int'(range_err_o), int'((es || ed) && ea >= CELLS));
        if (es || ed) begin
            exp_t e;
            e.due   = cyc + L;
            e.owner = es ? 2 : 1;
            e.data  = (ea < CELLS) ? vram_word(AW'(ea)) : 1'b0;
            sb.push_back(e);
        end
        if (sr && !es) streak = (streak < LIM) ? streak + 1 : LIM;
        else           streak = 0;
        $display("cyc=%0d req d%0d/s%0d gnt d%0d/s%0d addr=%0d", cyc, dr, sr,
                 disp_gnt_o, sim_gnt_o, vram_rd_address_o);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_gnt"}, int'(disp_gnt_o), 0);
        chk({tag, "_sim_gnt"}, int'(sim_gnt_o), 0);
        chk({tag, "_addr"}, int'(vram_rd_address_o), 0);
        chk({tag, "_disp_valid"}, int'(disp_valid_o), 0);
        chk({tag, "_sim_valid"}, int'(sim_valid_o), 0);
        chk({tag, "_disp_data"}, int'(disp_data_o), 0);
        chk({tag, "_sim_data"}, int'(sim_data_o), 0);
        chk({tag, "_range_err"}, int'(range_err_o), 0);
    endtask

    // Monitor: pops one expectation per returned beat.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                if (disp_valid_o || sim_valid_o) begin
                    chk("both_valid", int'(disp_valid_o && sim_valid_o), 0);
                    if (sb.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("ret_owner", disp_valid_o ? 1 : 2, e.owner);
                        chk("ret_cycle", cyc, e.due);
                        chk("ret_data", int'(disp_valid_o ? disp_data_o : sim_data_o), int'(e.data));
                        chk("other_data", int'(disp_valid_o ? sim_data_o : disp_data_o), 0);
                        $display("cyc=%0d return owner=%0d data=%0d", cyc, e.owner, e.data);
                    end
                end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("missing_return", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra, rb;
        // Reset state, with requests high to prove grants are held off.
        disp_req_i = 1'b1; sim_req_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        chk_all_zero("reset");
        #1;
        reset_i = 1'b0; disp_req_i = 1'b0; sim_req_i = 1'b0;

        // Sim alone streams addresses 0..9.
        for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1, AW'(i));

        // Both held: D,D,D,D,S repeating.
        for (int i = 0; i < 15; i++) begin
            ra = AW'($urandom_range(0, CELLS - 1));
            rb = AW'($urandom_range(0, CELLS - 1));
            drive(1'b1, ra, 1'b1, rb);
        end

        // Sim drops its request exactly when the force is due.
        for (int i = 0; i < 10 && streak < LIM; i++) drive(1'b1, AW'(100 + i), 1'b1, AW'(200 + i));
        chk("force_reached", streak, LIM);
        drive(1'b1, AW'(777), 1'b0, AW'(888));
        for (int i = 0; i < 6; i++) drive(1'b1, AW'(300 + i), 1'b1, AW'(400 + i));

        // Out-of-range grants.
        drive(1'b0, '0, 1'b1, AW'(CELLS));
        drive(1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, AW'(CELLS + 3));
        drive(1'b1, AW'(524287), 1'b0, '0);
        drive(1'b0, '0, 1'b1, AW'(CELLS - 1));

        // Alternating owners each cycle.
        for (int i = 0; i < 10; i++) begin
            ra = AW'($urandom_range(0, CELLS - 1));
            if (i % 2 == 0) drive(1'b1, ra, 1'b0, '0);
            else            drive(1'b0, '0, 1'b1, ra);
        end

        // Random traffic, occasionally out of range.
        for (int i = 0; i < 300; i++) begin
            ra = AW'($urandom_range(0, CELLS + 2000));
            rb = AW'($urandom_range(0, CELLS + 2000));
            drive($urandom_range(0, 99) < 60, ra, $urandom_range(0, 99) < 60, rb);
        end

        // Reset with two reads in flight.
        drive(1'b0, '0, 1'b1, AW'(11));
        drive(1'b1, AW'(12), 1'b0, '0);
        @(posedge clk_i);
        #1;
        disp_req_i = 1'b1; sim_req_i = 1'b1;
        #2;
        reset_i = 1'b1;
        sb.delete();
        streak = 0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk_i);
        #1;
        disp_req_i = 1'b0; sim_req_i = 1'b0;
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post_reset_disp_valid", int'(disp_valid_o), 0);
            chk("post_reset_sim_valid", int'(sim_valid_o), 0);
        end

        // Reads after reset work again.
        drive(1'b1, AW'(5), 1'b1, AW'(6));
        drive(1'b0, '0, 1'b1, AW'(6));
        for (int i = 0; i < L + 2; i++) drive(1'b0, '0, 1'b0, '0);
        chk("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
